// File: rtl/mux_rr_sched_if.sv
// Requester/output bundle for the round-robin mux scheduler.
// The master side owns req and the data lanes; the slave side is the scheduler.
interface mux_rr_sched_if #(
  parameter int DW = 1
);
  logic [3:0]    req;
  logic [DW-1:0] i0;
  logic [DW-1:0] i1;
  logic [DW-1:0] i2;
  logic [DW-1:0] i3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] q;
  logic          q_valid;

  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, sel, q, q_valid
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, sel, q, q_valid
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning the 4:1 select and output register; grants
// one requester at a time for up to BURST beats, then rotates.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; gnt=0, waits for any req
// ST_BUSY | owner holds grant; a beat moves i[owner] to q each cycle
module mux_rr_sched #(
  parameter int DW    = 1,
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          resetn,
  mux_rr_sched_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q_r;
  logic          q_valid_r;

  logic [DW-1:0] d_sel;
  logic          busy;
  logic          beat;
  logic          release_now;
  logic [1:0]    owner_nxt;

  // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] win(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    win = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) win = idx;
    end
  endfunction

  always_comb begin
    d_sel = bus.i0;
    case (owner)
      2'd0: d_sel = bus.i0;
      2'd1: d_sel = bus.i1;
      2'd2: d_sel = bus.i2;
      2'd3: d_sel = bus.i3;
      default: d_sel = bus.i0;
    endcase
  end

  assign busy        = (state == ST_BUSY);
  assign beat        = busy && bus.req[owner];
  // A drop and a final beat both hand the grant on at this edge.
  assign release_now = busy && (!bus.req[owner] || (cnt == CW'(BURST - 1)));
  assign owner_nxt   = owner + 2'd1;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= ST_IDLE;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      cnt       <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          q_valid_r <= 1'b0;
          if (|bus.req) begin
            state <= ST_BUSY;
            owner <= win(bus.req, ptr);
            cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (beat) begin
            q_r       <= d_sel;
            q_valid_r <= 1'b1;
            if (!release_now) cnt <= cnt + CW'(1);
          end else begin
            q_valid_r <= 1'b0;
          end
          if (release_now) begin
            ptr <= owner_nxt;
            // The releasing owner is scanned last, so it only re-wins alone.
            if (|bus.req) begin
              owner <= win(bus.req, owner_nxt);
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = busy ? (4'b0001 << owner) : 4'b0000;
  assign bus.sel     = owner;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: two instances (BURST=4 and BURST=2) share stimulus
// and are compared every cycle against a transaction-level round-robin model.
module tb_mux_rr_sched;

  localparam int DW = 8;

  logic          clk;
  logic          resetn;
  logic [3:0]    req;
  logic [DW-1:0] din [4];

  int checks = 0;
  int errors = 0;

  mux_rr_sched_if #(.DW(DW)) bus_a ();
  mux_rr_sched_if #(.DW(DW)) bus_b ();

  assign bus_a.req = req;
  assign bus_a.i0  = din[0];
  assign bus_a.i1  = din[1];
  assign bus_a.i2  = din[2];
  assign bus_a.i3  = din[3];
  assign bus_b.req = req;
  assign bus_b.i0  = din[0];
  assign bus_b.i1  = din[1];
  assign bus_b.i2  = din[2];
  assign bus_b.i3  = din[3];

  mux_rr_sched #(.DW(DW), .BURST(4), .CW(4)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  mux_rr_sched #(.DW(DW), .BURST(2), .CW(4)) dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 mirrors BURST=4, index 1 mirrors BURST=2.
  int burst_of [2] = '{4, 2};
  bit m_busy  [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_used  [2];
  int m_q     [2];
  bit m_qv    [2];

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return start;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
      m_used[k] = 0; m_q[k] = 0; m_qv[k] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input int d0, input int d1,
                            input int d2, input int d3);
    int d [4];
    bit done;
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k]) begin
        m_qv[k] = 0;
        if (r != 4'b0000) begin
          m_busy[k] = 1; m_owner[k] = pick(r, m_ptr[k]); m_used[k] = 0;
        end
      end else begin
        done = 0;
        if (r[m_owner[k]]) begin
          m_q[k] = d[m_owner[k]]; m_qv[k] = 1;
          m_used[k]++;
          if (m_used[k] == burst_of[k]) done = 1;
        end else begin
          m_qv[k] = 0; done = 1;
        end
        if (done) begin
          m_ptr[k] = (m_owner[k] + 1) % 4;
          if (r != 4'b0000) begin
            m_owner[k] = pick(r, (m_owner[k] + 1) % 4); m_used[k] = 0;
          end else begin
            m_busy[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_gnt",  32'(bus_a.gnt),     m_busy[0] ? 32'(1 << m_owner[0]) : 32'd0);
    check("a_sel",  32'(bus_a.sel),     32'(m_owner[0]));
    check("a_qv",   32'(bus_a.q_valid), 32'(m_qv[0]));
    check("a_q",    32'(bus_a.q),       32'(m_q[0]));
    check("b_gnt",  32'(bus_b.gnt),     m_busy[1] ? 32'(1 << m_owner[1]) : 32'd0);
    check("b_sel",  32'(bus_b.sel),     32'(m_owner[1]));
    check("b_qv",   32'(bus_b.q_valid), 32'(m_qv[1]));
    check("b_q",    32'(bus_b.q),       32'(m_q[1]));
  endtask

  task automatic rand_data();
    for (int k = 0; k < 4; k++) din[k] = DW'($urandom);
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are checked.
  task automatic cycle();
    @(posedge clk);
    model_step(req, int'(din[0]), int'(din[1]), int'(din[2]), int'(din[3]));
    #1;
    check_all();
  endtask

  task automatic run(input logic [3:0] r, input int n);
    for (int c = 0; c < n; c++) begin
      req = r;
      rand_data();
      cycle();
    end
  endtask

  initial begin
    resetn = 1'b1;
    req    = 4'b0000;
    rand_data();
    model_reset();
    #1;
    check_all();
    #1;
    resetn = 1'b0;

    // Single requester with incrementing data, continuous re-grant.
    for (int c = 0; c < 12; c++) begin
      req = 4'b0100;
      rand_data();
      din[2] = DW'(8'h10 + c);
      cycle();
    end
    run(4'b0000, 3);

    // All four requesting.
    run(4'b1111, 20);
    run(4'b0000, 3);

    // Early drop by requester 0 after one beat.
    run(4'b0011, 2);
    run(4'b0010, 6);
    run(4'b0000, 3);

    // Requester 3 releases while 0 also waits: rotation wraps to 0.
    run(4'b1000, 2);
    run(4'b1001, 14);
    run(4'b0000, 3);

    // Async reset in the middle of a requester-2 burst.
    run(4'b0100, 3);
    #2;
    resetn = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    resetn = 1'b0;
    run(4'b0100, 7);

    // Randomised traffic with sticky request lines.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      rand_data();
      cycle();
    end

    // Idle hold: q keeps last transferred value.
    run(4'b0000, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares the 4:1 select-and-register datapath between four requesters.
- It owns the 2-bit select, grants one requester at a time for a bounded burst, and registers the selected data onto a single output with a valid flag.
- It sits in front of the mux/flop stage and replaces static select wiring.

Parameters:
DW, 1, data width of each requester input and of q
BURST, 4, max beats per grant; legal 1..16
CW, 4, beat counter width; must satisfy 2**CW >= BURST

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous reset, active-high (asserted at 1), clears all state immediately
req  input  4  request per requester; bit n = requester n
i0  input  DW  requester 0 data
i1  input  DW  requester 1 data
i2  input  DW  requester 2 data
i3  input  DW  requester 3 data
gnt  output  4  one-hot grant, all-zero when idle
sel  output  2  current owner index, drives datapath select
q  output  DW  registered selected data
q_valid  output  1  q carries a beat transferred last cycle

Behaviour:
- State registers: busy, owner[1:0], ptr[1:0], cnt[CW-1:0], q, q_valid.
- Reset (async, resetn=1): busy=0, owner=0, ptr=0, cnt=0, q=0, q_valid=0. Hence gnt=0, sel=0.
- Combinational outputs:
  - gnt = busy ? onehot(owner) : 4'b0000.
  - sel = owner.
- Arbitration function win(p): first set bit of req scanning p, p+1, p+2, p+3 (mod 4).
- IDLE (busy=0):
  - q_valid<=0; q holds its value.
  - If |req: busy<=1, owner<=win(ptr), cnt<=0.
  - Otherwise remain idle.
- BUSY, req[owner]=1 (beat):
  - q<=i[owner], q_valid<=1.
  - If cnt==BURST-1, release. Otherwise cnt<=cnt+1.
- BUSY, req[owner]=0 (early drop):
  - No transfer: q_valid<=0, q holds.
  - Release.
- Release:
  - ptr<=owner+1 (wraps 3->0).
  - If |req: owner<=win(owner+1), cnt<=0, busy stays 1. This gives back-to-back grants with no bubble.
  - Else busy<=0.
  - The released owner may win again only if no other requester is pending. Its own req bit is evaluated last in the rotation.
- Latency:
  - req rises in idle cycle 0 -> gnt/sel valid cycle 1.
  - Data sampled at end of cycle 1 -> q/q_valid visible cycle 2.
  - Each beat has one cycle of latency from gnt to q_valid.
- Requester rule: while gnt[n]=1 and req[n]=1, requester n drives a new valid beat each cycle. Deasserting req ends its grant at that edge.
- Requests are level-sensitive. A req pulse shorter than the arbitration edge is lost; no queuing.
- BURST=1: every beat releases, giving strict one-beat round robin among active requesters.
- Reset mid-burst: all state clears asynchronously. q_valid drops immediately. After release, arbitration restarts from ptr=0.
- q is never updated without q_valid=1 in the following cycle. q holds its last value when q_valid=0.

Test Plan:
- Reset then single requester, BURST=4, DW=8:
  - Stimulus: req=0100 held, i2=0x10,0x11,... per cycle.
  - Required: gnt=0100 and sel=2 from cycle 1. q_valid=1 cycles 2-5 with q=0x10..0x13.
  - After the 4th beat, requester 2 is re-granted immediately (no other requester), so q_valid stays 1 continuously.
- All four requesting, BURST=2:
  - Stimulus: req=1111 constant.
  - Required: grant order 0,0,1,1,2,2,3,3,0,... with gnt one-hot and no idle cycle between owners. q_valid=1 every cycle from cycle 2.
- Early drop:
  - Stimulus: req=0011, owner 0 drops req after 1 beat.
  - Required: one beat of i0, then one cycle with q_valid=0 and q unchanged. Next, gnt=0010 and i1 beats follow.
- Pointer fairness:
  - Stimulus: owner 3 releases with req=1001.
  - Required: next owner=0 (wrap), ptr=0. Requester 3 is not re-granted until requester 0 releases.
- Async reset mid-burst:
  - Stimulus: resetn pulsed high between clock edges during owner 2 burst.
  - Required: gnt=0, sel=0, q=0, q_valid=0 immediately with no clock edge. With req=0100 after release, owner=2 is granted one cycle later and cnt restarts at 0.
- Idle hold:
  - Stimulus: req=0000 for 5 cycles after traffic.
  - Required: gnt=0, q_valid=0, and q retains the last transferred value.
